// File: rtl/alu_cmd_issuer.sv
// Command-side initiator for the 16-bit ALU breadboard: buffers (opcode, A, B) commands,
// drives each onto the ALU for RESULT_LAT cycles, then returns an in-order response.
module alu_cmd_issuer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned RESULT_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_opcode,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic [3:0]  alu_opcode,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_result,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [3:0]  rsp_opcode,
    output logic [15:0] rsp_result,
    output logic        rsp_error,
    output logic        busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(RESULT_LAT + 1);

    localparam logic [3:0] OP_ADD   = 4'b1000;
    localparam logic [3:0] OP_SUB   = 4'b1001;
    localparam logic [3:0] OP_CLEAR = 4'b1111;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [15:0] a;
        logic [15:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    // Opcodes with no ALU function are answered directly with an error response.
    function automatic logic is_legal(input logic [3:0] op);
        logic legal;
        case (op)
            4'b0111, 4'b1100, 4'b1101, 4'b1110: legal = 1'b0;
            default:                            legal = 1'b1;
        endcase
        return legal;
    endfunction

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_d;
    cmd_t          head;
    logic          empty;
    logic          push;
    logic          pop;

    state_t        state;
    state_t        state_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic          slot_free;
    logic          lat_done;

    logic [3:0]    alu_opcode_d;
    logic [15:0]   alu_a_d;
    logic [15:0]   alu_b_d;
    logic          rsp_valid_d;
    logic [3:0]    rsp_opcode_d;
    logic [15:0]   rsp_result_d;
    logic          rsp_error_d;
    logic          busy_d;
    logic          cmd_ready_d;

    assign head      = mem[rd_ptr];
    assign empty     = (count == '0);
    assign push      = cmd_valid & cmd_ready;
    assign slot_free = ~rsp_valid | rsp_ready;
    assign lat_done  = (({1'b0, cnt} + (CW+1)'(1)) >= (CW+1)'(RESULT_LAT));

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_opcode, cmd_a, cmd_b};
        end
    end

    always_comb begin
        count_d = count;
        if (push && !pop) begin
            count_d = count + (AW+1)'(1);
        end else if (!push && pop) begin
            count_d = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        pop          = 1'b0;
        alu_opcode_d = alu_opcode;
        alu_a_d      = alu_a;
        alu_b_d      = alu_b;
        rsp_valid_d  = rsp_valid & ~rsp_ready;
        rsp_opcode_d = rsp_opcode;
        rsp_result_d = rsp_result;
        rsp_error_d  = rsp_error;

        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    if (is_legal(head.opcode)) begin
                        pop          = 1'b1;
                        alu_opcode_d = head.opcode;
                        alu_a_d      = head.a;
                        alu_b_d      = head.b;
                        cnt_d        = '0;
                        state_d      = S_ISSUE;
                    end else if (slot_free) begin
                        pop          = 1'b1;
                        rsp_valid_d  = 1'b1;
                        rsp_opcode_d = head.opcode;
                        rsp_result_d = '0;
                        rsp_error_d  = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (cnt != CW'(RESULT_LAT)) begin
                    cnt_d = cnt + CW'(1);
                end
                if (lat_done && slot_free) begin
                    rsp_valid_d  = 1'b1;
                    rsp_opcode_d = alu_opcode;
                    rsp_result_d = alu_result;
                    rsp_error_d  = alu_overflow &
                                   ((alu_opcode == OP_ADD) | (alu_opcode == OP_SUB));
                    // CLEAR is presented to the ALU during the following cycle.
                    alu_opcode_d = OP_CLEAR;
                    alu_a_d      = '0;
                    alu_b_d      = '0;
                    state_d      = S_CLEAR;
                end
            end
            S_CLEAR: begin
                alu_opcode_d = OP_CLEAR;
                alu_a_d      = '0;
                alu_b_d      = '0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d      = (count_d != '0) | (state_d != S_IDLE) | rsp_valid_d;
        cmd_ready_d = (count_d != (AW+1)'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode <= OP_CLEAR;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_opcode <= '0;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
            busy       <= 1'b0;
            cmd_ready  <= 1'b1;
        end else begin
            alu_opcode <= alu_opcode_d;
            alu_a      <= alu_a_d;
            alu_b      <= alu_b_d;
            rsp_valid  <= rsp_valid_d;
            rsp_opcode <= rsp_opcode_d;
            rsp_result <= rsp_result_d;
            rsp_error  <= rsp_error_d;
            busy       <= busy_d;
            cmd_ready  <= cmd_ready_d;
        end
    end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Command-side initiator for the 16-bit ALU breadboard. Accepts (opcode, A, B) commands over a valid/ready port and buffers them in a small FIFO. Drives each one onto the ALU operand/opcode inputs, holds it for the ALU's register latency, then samples the result and overflow. Returns an in-order response over a second valid/ready port, and inserts a CLEAR opcode between operations.

## Interface
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- RESULT_LAT, 2, cycles alu_* are held before result/overflow are sampled (≥1)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  FIFO not full
- cmd_opcode  input  4  ALU opcode
- cmd_a  input  16  operand A
- cmd_b  input  16  operand B
- alu_opcode  output  4  to ALU opcode (registered)
- alu_a  output  16  to ALU A input (registered)
- alu_b  output  16  to ALU B input (registered)
- alu_result  input  16  ALU final output
- alu_overflow  input  1  ALU adder overflow
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_opcode  output  4  opcode of the completed command
- rsp_result  output  16  captured result
- rsp_error  output  1  overflow on ADD/SUB, or illegal opcode
- busy  output  1  FIFO non-empty, FSM not IDLE, or rsp_valid

## Operation
- Legal opcodes: 0000 AND, 0001 OR, 0010 NOT, 0011 XOR, 0100 NAND, 0101 NOR, 0110 XNOR, 1000 ADD, 1001 SUB, 1010 SHR, 1011 SHL, 1111 CLEAR. All others are illegal.
- Push on cmd_valid & cmd_ready.
- cmd_ready = !full. It does not depend on a same-cycle pop.
- Response slot is free when rsp_valid==0, or when rsp_valid & rsp_ready in that cycle.
- FSM states:
  - IDLE
    - FIFO empty: stay.
    - Head legal: pop, load alu_opcode/alu_a/alu_b from the head, clear wait counter, go ISSUE.
    - Head illegal and slot free: pop, load response (result 0, error 1), stay IDLE. alu_* unchanged.
    - Head illegal and slot not free: no pop.
  - ISSUE
    - Hold alu_*. Counter increments each cycle.
    - Counter reaches RESULT_LAT and slot free: capture alu_result into rsp_result, set rsp_error = alu_overflow & (opcode==ADD | opcode==SUB), set rsp_opcode, set rsp_valid, go CLEAR.
    - Slot not free: stay in ISSUE, alu_* held, counter saturates.
  - CLEAR: drive alu_opcode=1111 and alu_a=alu_b=0 for one cycle, go IDLE.
- rsp_valid falls on rsp_ready unless a new response loads in the same cycle. In that case it stays 1 with the new data.
- Response fields are stable while rsp_valid & !rsp_ready.
- Responses are returned strictly in command order.

## Timing
- Reset values: alu_opcode=1111, alu_a=alu_b=0, rsp_valid=0, rsp_opcode=0, rsp_result=0, rsp_error=0, busy=0, cmd_ready=1, FIFO empty, state IDLE.
- Push at edge E0 → pop at E1, alu_* valid after E1.
- Capture at E1+RESULT_LAT, with rsp_valid high after that edge.
- CLEAR cycle ends at E2+RESULT_LAT.
- Push-to-response latency: RESULT_LAT+1 edges.
- Sustained throughput: one op per RESULT_LAT+2 cycles.
- Illegal opcode: response one edge after it reaches the FIFO head.
- Capacity under full backpressure: DEPTH + 2 commands accepted (one in the response register, one stalled in ISSUE, DEPTH in the FIFO).
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The FIFO is flushed and any pending response is discarded. After rst_n rises, no stale response appears.
- Simultaneous push and pop on a non-full FIFO: both take effect and the count is unchanged.
- FIFO pointers wrap modulo DEPTH.

## Test plan
- AND, a=0x250A, b=0x0F0F:
  - alu_opcode=0000 for RESULT_LAT cycles, then 1111 for one cycle.
  - Response rsp_result=0x050A, rsp_error=0, rsp_opcode=0000.
- ADD 0x001E+0x0007, then ADD 0xBC40+0x9C40, with rsp_ready=1:
  - Responses are 0x0025 / error 0, then 0x5880 / error 1, in order.
- SUB 0x0007−0x001E → 0xFFE9, error 0. SUB 0x001E−0x0007 → 0x0017, error 0. SHL 0xCE67 → 0x9CCE. SHR 0xCE67 → 0x6733.
- Backpressure:
  - Hold rsp_ready=0 and push until cmd_ready=0: exactly 6 commands accepted (DEPTH=4), and alu_* stay frozen in ISSUE.
  - Then set rsp_ready=1: all 6 responses arrive in order with correct values and no duplicates.
- Illegal opcode 1100, a=0xFFFF:
  - alu_opcode stays 1111.
  - Response is rsp_result=0x0000, rsp_error=1, one edge after pop.
  - The following legal command completes normally.
- Reset mid-ISSUE of a SUB:
  - Drop rst_n asynchronously: outputs take reset values immediately and busy=0.
  - After release: no response appears, and a new AND completes with correct latency.
